// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner: one digit per CLK_DIV slot, dead first cycle per slot,
// digits captured once per frame into a shadow register, optional leading-zero blanking.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    en,
  input  logic                    blank_lz,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_sel_o,
  output logic [IDX_W-1:0]        scan_idx_o,
  output logic                    frame_tick_o
);

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{DIG_ACT_LOW}};

  logic [PRE_W-1:0]        pre_cnt;
  logic [IDX_W-1:0]        scan_idx;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    tick_q;

  logic                    pre_last;
  logic                    idx_last;
  logic                    slot_dead;
  logic                    load;
  logic [3:0]              cur_digit;
  logic [6:0]              cur_lit;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   blanked;

  // a..g lit pattern, bit0 = a; non-BCD codes render as a lone dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] lit;
    case (d)
      4'd0:    lit = 7'b0111111;
      4'd1:    lit = 7'b0000110;
      4'd2:    lit = 7'b1011011;
      4'd3:    lit = 7'b1001111;
      4'd4:    lit = 7'b1100110;
      4'd5:    lit = 7'b1101101;
      4'd6:    lit = 7'b1111101;
      4'd7:    lit = 7'b0000111;
      4'd8:    lit = 7'b1111111;
      4'd9:    lit = 7'b1101111;
      default: lit = 7'b1000000;
    endcase
    return lit;
  endfunction

  always_comb begin
    pre_last  = (pre_cnt == PRE_LAST);
    idx_last  = (scan_idx == IDX_LAST);
    slot_dead = (pre_cnt == '0);
    load      = en && slot_dead && (scan_idx == '0);
    cur_digit = shadow[4*scan_idx +: 4];
    cur_lit   = decode(cur_digit);
    onehot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_idx;
  end

  // Walk from the most significant digit down; a digit blanks only while everything
  // at and above it is zero. Digit 0 always shows.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blanked    = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (shadow[4*i +: 4] == 4'd0);
      blanked[i] = blank_lz && zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      pre_cnt  <= '0;
      scan_idx <= '0;
      shadow   <= '0;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
      idx_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      if (en) begin
        if (pre_last) begin
          pre_cnt  <= '0;
          scan_idx <= idx_last ? '0 : scan_idx + 1'b1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end

      if (load)
        shadow <= digits_i;

      idx_q  <= scan_idx;
      tick_q <= load;

      // The first cycle of every slot is dark so the previous digit cannot ghost.
      if (!en || slot_dead)
        dig_q <= DIG_OFF;
      else
        dig_q <= DIG_ACT_LOW ? ~onehot : onehot;

      if (!en || slot_dead || blanked[scan_idx])
        seg_q <= SEG_OFF;
      else
        seg_q <= SEG_ACT_LOW ? ~cur_lit : cur_lit;
    end
  end

  assign seg_o        = seg_q;
  assign dig_sel_o    = dig_q;
  assign scan_idx_o   = idx_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (8 digits, 4-cycle slots, active-low outputs) with a
// cycle-level reference model feeding an expected-output queue.
module tb_seg_scan_driver;

  localparam int N   = 8;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          en = 1'b0;
  logic          blank_lz = 1'b0;
  logic [4*N-1:0] digits = '0;
  logic [6:0]    seg;
  logic [N-1:0]  dig;
  logic [2:0]    idx;
  logic          tick;

  int total = 0;
  int bad   = 0;

  seg_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(DIV), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rstb(rstb), .en(en), .blank_lz(blank_lz), .digits_i(digits),
    .seg_o(seg), .dig_sel_o(dig), .scan_idx_o(idx), .frame_tick_o(tick)
  );

  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  logic [1:0]     m_pre;
  logic [2:0]     m_idx;
  logic [4*N-1:0] m_sh;
  logic [18:0]    exp_q[$];
  logic [18:0]    sb_e;

  function automatic logic [6:0] lit_of(input logic [3:0] d);
    logic [6:0] tab [16];
    tab[0] = 7'h3F; tab[1] = 7'h06; tab[2] = 7'h5B; tab[3] = 7'h4F;
    tab[4] = 7'h66; tab[5] = 7'h6D; tab[6] = 7'h7D; tab[7] = 7'h07;
    tab[8] = 7'h7F; tab[9] = 7'h6F;
    for (int c = 10; c < 16; c++) tab[c] = 7'h40;
    return tab[d];
  endfunction

  function automatic logic [18:0] model_out(input logic en_v, input logic bl,
                                            input logic [1:0] p, input logic [2:0] i,
                                            input logic [4*N-1:0] sh);
    logic [6:0] s;
    logic [7:0] d;
    logic       t;
    s = 7'h7F;
    d = 8'hFF;
    t = en_v && (p == 2'd0) && (i == 3'd0);
    if (en_v && p != 2'd0) begin
      d = ~(8'h01 << i);
      if (!(i != 3'd0 && bl && (sh >> (4*i)) == 0))
        s = ~lit_of(sh[4*i +: 4]);
    end
    return {s, d, i, t};
  endfunction

  always @(posedge clk) begin
    if (!rstb) begin
      exp_q.push_back({7'h7F, 8'hFF, 3'd0, 1'b0});
      m_pre <= 2'd0;
      m_idx <= 3'd0;
      m_sh  <= '0;
    end else begin
      exp_q.push_back(model_out(en, blank_lz, m_pre, m_idx, m_sh));
      if (en && m_pre == 2'd0 && m_idx == 3'd0) m_sh <= digits;
      if (en) begin
        m_pre <= m_pre + 2'd1;
        if (m_pre == 2'd3) m_idx <= m_idx + 3'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      sb_e = exp_q.pop_front();
      total++;
      if ({seg, dig, idx, tick} !== sb_e) begin
        bad++;
        $display("FAIL scoreboard t=%0t got seg=%h dig=%h idx=%0d tick=%b want seg=%h dig=%h idx=%0d tick=%b",
                 $time, seg, dig, idx, tick, sb_e[18:12], sb_e[11:4], sb_e[3:1], sb_e[0]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_active_slot(input logic [2:0] k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (idx === k && dig !== 8'hFF) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstb = 1'b0;
    en   = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({seg, dig, idx, tick} !== {7'h7F, 8'hFF, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got seg=%h dig=%h idx=%0d tick=%b want 7f ff 0 0", seg, dig, idx, tick);
    end
  endtask

  task automatic test_basic_display();
    logic [6:0] es;
    logic [7:0] ed;
    digits   = 32'h0000_0042;
    blank_lz = 1'b1;
    en       = 1'b1;
    rstb     = 1'b1;
    @(negedge clk);
    total++;
    if (tick !== 1'b1 || dig !== 8'hFF) begin
      bad++;
      $display("FAIL first_tick got tick=%b dig=%h want 1 ff", tick, dig);
    end
    for (int j = 1; j < 32; j++) begin
      @(negedge clk);
      if (j % 4 != 0) begin
        ed = ~(8'h01 << (j / 4));
        es = (j / 4 == 0) ? 7'h24 : (j / 4 == 1) ? 7'h19 : 7'h7F;
        total++;
        if (dig !== ed || seg !== es) begin
          bad++;
          $display("FAIL basic_42 j=%0d got seg=%h dig=%h want seg=%h dig=%h", j, seg, dig, es, ed);
        end
      end
    end
  endtask

  task automatic test_scan_timing();
    bit ok;
    logic [7:0] ed;
    wait_tick(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL timing_wait got no tick want tick"); end
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      ed = (j % 4 == 0) ? 8'hFF : ~(8'h01 << ((j / 4) % 8));
      total++;
      if ({dig, idx, tick} !== {ed, 3'((j / 4) % 8), 1'(j == 32)}) begin
        bad++;
        $display("FAIL scan_timing j=%0d got dig=%h idx=%0d tick=%b want dig=%h idx=%0d tick=%b",
                 j, dig, idx, tick, ed, (j / 4) % 8, j == 32);
      end
    end
  endtask

  task automatic test_zero_and_dash();
    bit ok;
    logic [6:0] es;
    blank_lz = 1'b0;
    digits   = 32'h0;
    wait_tick(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL zero_wait got no tick want tick"); end
    for (int j = 1; j < 32; j++) begin
      @(negedge clk);
      es = (j % 4 == 0) ? 7'h7F : 7'h40;
      total++;
      if (seg !== es) begin
        bad++;
        $display("FAIL all_zero j=%0d got seg=%h want %h", j, seg, es);
      end
    end
    digits = 32'h0000_B000;
    wait_tick(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL dash_wait got no tick want tick"); end
    for (int j = 1; j < 32; j++) begin
      @(negedge clk);
      es = (j % 4 == 0) ? 7'h7F : (j / 4 == 3) ? 7'h3F : 7'h40;
      total++;
      if (seg !== es) begin
        bad++;
        $display("FAIL dash_b j=%0d got seg=%h want %h", j, seg, es);
      end
    end
  endtask

  task automatic test_no_tear();
    bit ok;
    logic [6:0] es;
    blank_lz = 1'b1;
    digits   = 32'h0000_0123;
    wait_tick(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL tear_wait got no tick want tick"); end
    for (int f = 0; f < 2; f++) begin
      for (int j = 1; j <= 32; j++) begin
        @(negedge clk);
        if (f == 0 && j == 10) digits = 32'h0000_0456;
        if (j == 32) begin
          total++;
          if (tick !== 1'b1) begin
            bad++;
            $display("FAIL tear_tick f=%0d got tick=%b want 1", f, tick);
          end
        end else if (j % 4 != 0) begin
          case (j / 4)
            0:       es = (f == 0) ? 7'h30 : 7'h02;
            1:       es = (f == 0) ? 7'h24 : 7'h12;
            2:       es = (f == 0) ? 7'h79 : 7'h19;
            default: es = 7'h7F;
          endcase
          total++;
          if (seg !== es) begin
            bad++;
            $display("FAIL no_tear f=%0d j=%0d got seg=%h want %h", f, j, seg, es);
          end
        end
      end
    end
  endtask

  task automatic test_en_pause();
    bit ok;
    digits   = 32'h0034_5678;
    blank_lz = 1'b1;
    wait_tick(ok);
    wait_active_slot(3'd2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL pause_wait got no slot 2 want slot 2"); end
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({seg, dig, idx} !== {7'h7F, 8'hFF, 3'd2}) begin
        bad++;
        $display("FAIL paused c=%0d got seg=%h dig=%h idx=%0d want 7f ff 2", c, seg, dig, idx);
      end
    end
    en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({seg, dig, idx} !== {7'h02, 8'hFB, 3'd2}) begin
        bad++;
        $display("FAIL resume c=%0d got seg=%h dig=%h idx=%0d want 02 fb 2", c, seg, dig, idx);
      end
    end
    @(negedge clk);
    total++;
    if ({dig, idx} !== {8'hFF, 3'd3}) begin
      bad++;
      $display("FAIL resume_next got dig=%h idx=%0d want ff 3", dig, idx);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    logic [6:0] es;
    wait_active_slot(3'd5, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_wait got no slot 5 want slot 5"); end
    rstb   = 1'b0;
    digits = 32'h0000_0789;
    @(negedge clk);
    total++;
    if ({seg, dig, idx, tick} !== {7'h7F, 8'hFF, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset got seg=%h dig=%h idx=%0d tick=%b want 7f ff 0 0", seg, dig, idx, tick);
    end
    rstb = 1'b1;
    @(negedge clk);
    total++;
    if ({dig, idx, tick} !== {8'hFF, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL restart got dig=%h idx=%0d tick=%b want ff 0 1", dig, idx, tick);
    end
    for (int j = 1; j < 12; j++) begin
      @(negedge clk);
      if (j % 4 != 0) begin
        es = (j / 4 == 0) ? 7'h10 : (j / 4 == 1) ? 7'h00 : 7'h78;
        total++;
        if (seg !== es) begin
          bad++;
          $display("FAIL restart_789 j=%0d got seg=%h want %h", j, seg, es);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_display();
    test_scan_timing();
    test_zero_and_dash();
    test_no_tear();
    test_en_pause();
    test_reset_mid_scan();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
